// File: rtl/packet_width_adapter.sv
// rtl/packet_width_adapter.sv - packet-aware valid/ready stream width converter
// Packet handling (ikeep/ilast, partial flush, olast/okeep) is enabled by `define PWA_LAST_EN.
module packet_width_adapter #(
  parameter int IW   = 64,
  parameter int OW   = 32,
  parameter int UNIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IW-1:0]      idata_i,
  input  logic [IW/UNIT-1:0] ikeep_i,
  input  logic               ilast_i,
  input  logic               ivalid_i,
  output logic               iready_o,
  output logic [OW-1:0]      odata_o,
  output logic [OW/UNIT-1:0] okeep_o,
  output logic               olast_o,
  output logic               ovalid_o,
  input  logic               oready_i
);
  localparam int IU = IW / UNIT;
  localparam int OU = OW / UNIT;

  if (IW == OW) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ rst;
    assign iready_o   = oready_i;
    assign odata_o    = idata_i;
    assign ovalid_o   = ivalid_i;
`ifdef PWA_LAST_EN
    assign okeep_o    = ikeep_i;
    assign olast_o    = ilast_i;
`else
    logic unused_pkt;
    assign unused_pkt = ^{ikeep_i, ilast_i};
    assign okeep_o    = '1;
    assign olast_o    = 1'b0;
`endif
  end else begin : g_conv
    localparam int BW = IW + OW;
    localparam int CW = $clog2(IU + OU + 1);
    localparam logic [CW-1:0] IU_C = CW'(IU);
    localparam logic [CW-1:0] OU_C = CW'(OU);

    // Valid units sit left-justified in buf_q; everything below cnt_q is kept zero.
    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lastp_q, lastp_d;
    logic          iready, ovalid, olast, ifire, ofire;
    logic [OU-1:0] okeep;
    logic [CW-1:0] out_units, rem_units, in_units;
    logic [IW-1:0] in_masked;

`ifndef PWA_LAST_EN
    logic unused_pkt;
    assign unused_pkt = ^{ikeep_i, ilast_i};
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        buf_q   <= '0;
        cnt_q   <= '0;
        lastp_q <= 1'b0;
      end else begin
        buf_q   <= buf_d;
        cnt_q   <= cnt_d;
        lastp_q <= lastp_d;
      end
    end

    always_comb begin : p_flags
      iready = !lastp_q && (cnt_q <= OU_C);
`ifdef PWA_LAST_EN
      ovalid = (cnt_q >= OU_C) || (lastp_q && (cnt_q != '0));
      olast  = lastp_q && (cnt_q <= OU_C);
      okeep  = ~({OU{1'b1}} >> cnt_q);
`else
      ovalid = cnt_q >= OU_C;
      olast  = 1'b0;
      okeep  = '1;
`endif
    end

    always_comb begin : p_next
      ifire     = ivalid_i && iready;
      ofire     = ovalid && oready_i;
      out_units = '0;
      if (ofire) out_units = (cnt_q < OU_C) ? cnt_q : OU_C;
      rem_units = cnt_q - out_units;
      in_units  = '0;
      in_masked = '0;
      lastp_d   = lastp_q;
      if (ofire && olast) lastp_d = 1'b0;
      if (ifire) begin
`ifdef PWA_LAST_EN
        if (ilast_i) begin
          for (int k = 0; k < IU; k++) in_units = in_units + CW'(ikeep_i[k]);
          lastp_d = 1'b1;
        end else begin
          in_units = IU_C;
        end
`else
        in_units = IU_C;
`endif
        for (int k = 0; k < IU; k++)
          if (CW'(k) < in_units) in_masked[IW-1-k*UNIT -: UNIT] = idata_i[IW-1-k*UNIT -: UNIT];
      end
      // Drain from the top, then drop new units directly under whatever remains.
      buf_d = (buf_q << (int'(out_units) * UNIT))
            | ({in_masked, {OW{1'b0}}} >> (int'(rem_units) * UNIT));
      cnt_d = rem_units + in_units;
    end

    assign iready_o = iready;
    assign ovalid_o = ovalid;
    assign olast_o  = olast;
    assign okeep_o  = okeep;
    assign odata_o  = buf_q[BW-1 -: OW];
  end
endmodule

// File: tb/tb_packet_width_adapter.sv
// tb/tb_packet_width_adapter.sv - self-checking bench for packet_width_adapter (64->32 and 32->64)
module tb_packet_width_adapter;
`ifdef PWA_LAST_EN
  localparam logic LE = 1'b1;
`else
  localparam logic LE = 1'b0;
`endif

  logic        clk, rst;
  logic [63:0] idata_a;
  logic [7:0]  ikeep_a;
  logic        ilast_a, ivalid_a, iready_a, olast_a, ovalid_a, oready_a;
  logic [31:0] odata_a;
  logic [3:0]  okeep_a;
  logic [31:0] idata_b;
  logic [3:0]  ikeep_b;
  logic        ilast_b, ivalid_b, iready_b, olast_b, ovalid_b, oready_b;
  logic [63:0] odata_b;
  logic [7:0]  okeep_b;

  int checks = 0;
  int failures = 0;

  packet_width_adapter #(.IW(64), .OW(32), .UNIT(8)) dut_a (
    .clk(clk), .rst(rst), .idata_i(idata_a), .ikeep_i(ikeep_a), .ilast_i(ilast_a),
    .ivalid_i(ivalid_a), .iready_o(iready_a), .odata_o(odata_a), .okeep_o(okeep_a),
    .olast_o(olast_a), .ovalid_o(ovalid_a), .oready_i(oready_a));

  packet_width_adapter #(.IW(32), .OW(64), .UNIT(8)) dut_b (
    .clk(clk), .rst(rst), .idata_i(idata_b), .ikeep_i(ikeep_b), .ilast_i(ilast_b),
    .ivalid_i(ivalid_b), .iready_o(iready_b), .odata_o(odata_b), .okeep_o(okeep_b),
    .olast_o(olast_b), .ovalid_o(ovalid_b), .oready_i(oready_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  typedef struct {
    logic        rst, iv;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l, ordy, chk, ev, er;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
  } vec_t;
  vec_t vq[$];

  task automatic v(input logic r, input logic iv, input logic [63:0] d, input logic [7:0] k,
                   input logic l, input logic ordy, input logic chk, input logic ev,
                   input logic er, input logic [31:0] ed, input logic [3:0] ek, input logic el);
    vec_t x;
    x.rst = r; x.iv = iv; x.d = d; x.k = k; x.l = l; x.ordy = ordy;
    x.chk = chk; x.ev = ev; x.er = er; x.ed = ed; x.ek = ek; x.el = el;
    vq.push_back(x);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic a_send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    ivalid_a = 1'b1; idata_a = d; ikeep_a = k; ilast_a = l;
    while (!iready_a && n < 20) begin @(negedge clk); n++; end
    check("a_send_ready", 64'(iready_a), 64'd1);
    @(negedge clk);
    ivalid_a = 1'b0;
  endtask

  task automatic b_send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    ivalid_b = 1'b1; idata_b = d; ikeep_b = k; ilast_b = l;
    while (!iready_b && n < 20) begin @(negedge clk); n++; end
    check("b_send_ready", 64'(iready_b), 64'd1);
    @(negedge clk);
    ivalid_b = 1'b0;
  endtask

  task automatic a_expect(input string name, input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    while (!ovalid_a && n < 20) begin @(negedge clk); n++; end
    check({name, "_valid"}, 64'(ovalid_a), 64'd1);
    check({name, "_data"}, 64'(odata_a), 64'(d));
    check({name, "_keep"}, 64'(okeep_a), 64'(k));
    check({name, "_last"}, 64'(olast_a), 64'(l));
    oready_a = 1'b1;
    @(negedge clk);
    oready_a = 1'b0;
  endtask

  task automatic b_expect(input string name, input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    while (!ovalid_b && n < 20) begin @(negedge clk); n++; end
    check({name, "_valid"}, 64'(ovalid_b), 64'd1);
    check({name, "_data"}, odata_b, d);
    check({name, "_keep"}, 64'(okeep_b), 64'(k));
    check({name, "_last"}, 64'(olast_b), 64'(l));
    oready_b = 1'b1;
    @(negedge clk);
    oready_b = 1'b0;
  endtask

  logic [63:0] pkt[20];
  logic [31:0] exp_w[40];
  logic [31:0] hd;
  logic [3:0]  hk;
  logic        hl, held, started;
  int          beat, got, gaps;

  initial begin
    rst = 1'b1;
    idata_a = '0; ikeep_a = '0; ilast_a = 1'b0; ivalid_a = 1'b0; oready_a = 1'b0;
    idata_b = '0; ikeep_b = '0; ilast_b = 1'b0; ivalid_b = 1'b0; oready_b = 1'b0;

    // rst iv data                    keep   l  ordy chk ev er  odata          okeep l
    v(1, 0, 64'h0,                 8'h00, 0, 0,  0, 0, 0, 32'h0,        4'h0, 0);
    v(1, 0, 64'h0,                 8'h00, 0, 0,  0, 0, 0, 32'h0,        4'h0, 0);
`ifdef PWA_LAST_EN
    v(0, 1, 64'h0011223344556677, 8'hFF, 1, 1,  1, 0, 1, 32'h0,        4'h0, 0);
    v(0, 0, 64'h0,                 8'h00, 0, 1,  1, 1, 0, 32'h00112233, 4'hF, 0);
    v(0, 1, 64'hAABBCCDDEEFF0011, 8'hE0, 1, 1,  1, 1, 0, 32'h44556677, 4'hF, 1);
    v(0, 1, 64'hAABBCCDDEEFF0011, 8'hE0, 1, 1,  1, 0, 1, 32'h0,        4'h0, 0);
    v(0, 1, 64'h0102030405060708, 8'h00, 0, 1,  1, 1, 0, 32'hAABBCC00, 4'hE, 1);
    v(0, 1, 64'h0102030405060708, 8'h00, 0, 1,  1, 0, 1, 32'h0,        4'h0, 0);
    v(0, 1, 64'h1112131415161718, 8'hFF, 1, 1,  1, 1, 0, 32'h01020304, 4'hF, 0);
    v(0, 1, 64'h1112131415161718, 8'hFF, 1, 1,  1, 1, 1, 32'h05060708, 4'hF, 0);
    v(0, 0, 64'h0,                 8'h00, 0, 1,  1, 1, 0, 32'h11121314, 4'hF, 0);
    v(0, 0, 64'h0,                 8'h00, 0, 1,  1, 1, 0, 32'h15161718, 4'hF, 1);
    v(0, 0, 64'h0,                 8'h00, 0, 1,  1, 0, 1, 32'h0,        4'h0, 0);
`else
    v(0, 1, 64'h0011223344556677, 8'hFF, 1, 1,  1, 0, 1, 32'h0,        4'hF, 0);
    v(0, 0, 64'h0,                 8'h00, 0, 1,  1, 1, 0, 32'h00112233, 4'hF, 0);
    v(0, 1, 64'hAABBCCDDEEFF0011, 8'hE0, 1, 1,  1, 1, 1, 32'h44556677, 4'hF, 0);
    v(0, 1, 64'hAABBCCDDEEFF0011, 8'hE0, 1, 1,  1, 1, 0, 32'hAABBCCDD, 4'hF, 0);
    v(0, 1, 64'h0102030405060708, 8'h00, 0, 1,  1, 1, 1, 32'hEEFF0011, 4'hF, 0);
    v(0, 1, 64'h0102030405060708, 8'h00, 0, 1,  1, 1, 0, 32'h01020304, 4'hF, 0);
    v(0, 1, 64'h1112131415161718, 8'hFF, 1, 1,  1, 1, 1, 32'h05060708, 4'hF, 0);
    v(0, 1, 64'h1112131415161718, 8'hFF, 1, 1,  1, 1, 0, 32'h11121314, 4'hF, 0);
    v(0, 0, 64'h0,                 8'h00, 0, 1,  1, 1, 1, 32'h15161718, 4'hF, 0);
    v(0, 0, 64'h0,                 8'h00, 0, 1,  1, 0, 1, 32'h0,        4'hF, 0);
    v(0, 0, 64'h0,                 8'h00, 0, 1,  1, 0, 1, 32'h0,        4'hF, 0);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; ivalid_a = vq[i].iv; idata_a = vq[i].d; ikeep_a = vq[i].k;
      ilast_a = vq[i].l; oready_a = vq[i].ordy;
      if (vq[i].chk) begin
        check($sformatf("tbl%0d_ovalid", i), 64'(ovalid_a), 64'(vq[i].ev));
        check($sformatf("tbl%0d_iready", i), 64'(iready_a), 64'(vq[i].er));
        check($sformatf("tbl%0d_odata", i), 64'(odata_a), 64'(vq[i].ed));
        check($sformatf("tbl%0d_okeep", i), 64'(okeep_a), 64'(vq[i].ek));
        check($sformatf("tbl%0d_olast", i), 64'(olast_a), 64'(vq[i].el));
      end
    end

    // 20-beat packet with a 5-cycle consumer stall in the middle.
    for (int i = 0; i < 20; i++) begin
      pkt[i] = {$urandom, $urandom};
      exp_w[2*i] = pkt[i][63:32];
      exp_w[2*i+1] = pkt[i][31:0];
    end
    beat = 0; got = 0; gaps = 0; held = 1'b0; started = 1'b0;
    hd = '0; hk = '0; hl = 1'b0;
    for (int c = 0; c < 300 && got < 40; c++) begin
      @(negedge clk);
      oready_a = !(c >= 12 && c < 17);
      ivalid_a = (beat < 20);
      idata_a = pkt[beat < 20 ? beat : 0];
      ikeep_a = 8'hFF;
      ilast_a = (beat == 19);
      if (held) begin
        check("bp_hold_valid", 64'(ovalid_a), 64'd1);
        check("bp_hold_data", 64'(odata_a), 64'(hd));
        check("bp_hold_keep", 64'(okeep_a), 64'(hk));
        check("bp_hold_last", 64'(olast_a), 64'(hl));
      end
      if (started && !ovalid_a) gaps++;
      if (ovalid_a) started = 1'b1;
      if (ovalid_a && oready_a) begin
        check($sformatf("bp_word%0d_data", got), 64'(odata_a), 64'(exp_w[got]));
        check($sformatf("bp_word%0d_keep", got), 64'(okeep_a), 64'hF);
        check($sformatf("bp_word%0d_last", got), 64'(olast_a), 64'(LE && got == 39));
        got++;
      end
      held = ovalid_a && !oready_a;
      hd = odata_a; hk = okeep_a; hl = olast_a;
      if (ivalid_a && iready_a) beat++;
    end
    check("bp_word_count", 64'(got), 64'd40);
    check("bp_output_gaps", 64'(gaps), 64'd0);
    @(negedge clk);
    oready_a = 1'b0;
    ivalid_a = 1'b0;

    b_send(32'h11111111, 4'hF, 1'b0);
    b_send(32'h22222222, 4'hF, 1'b1);
    b_expect("b_two", 64'h1111111122222222, 8'hFF, LE);
    b_send(32'hDEADBEEF, 4'hF, 1'b1);
`ifdef PWA_LAST_EN
    b_expect("b_single", 64'hDEADBEEF00000000, 8'hF0, 1'b1);
`else
    check("b_residual_wait", 64'(ovalid_b), 64'd0);
    b_send(32'hCAFEF00D, 4'hF, 1'b0);
    b_expect("b_fill", 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0);
`endif
    check("b_empty_ovalid", 64'(ovalid_b), 64'd0);
    check("b_empty_iready", 64'(iready_b), 64'd1);

    // Reset while a partial packet is buffered, then a clean packet.
    a_send(64'hAABBCCDDEEFF0011, 8'hE0, 1'b1);
    check("rst_pre_ovalid", 64'(ovalid_a), 64'd1);
    check("rst_pre_iready", 64'(iready_a), 64'd0);
    check("rst_pre_odata", 64'(odata_a), LE ? 64'hAABBCC00 : 64'hAABBCCDD);
    check("rst_pre_okeep", 64'(okeep_a), LE ? 64'hE : 64'hF);
    check("rst_pre_olast", 64'(olast_a), 64'(LE));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ovalid", 64'(ovalid_a), 64'd0);
    check("rst_mid_iready", 64'(iready_a), 64'd1);
    check("rst_mid_odata", 64'(odata_a), 64'd0);
    check("rst_mid_okeep", 64'(okeep_a), LE ? 64'h0 : 64'hF);
    check("rst_mid_olast", 64'(olast_a), 64'd0);
    a_send(64'h0123456789ABCDEF, 8'hFF, 1'b1);
    a_expect("post_hi", 32'h01234567, 4'hF, 1'b0);
    a_expect("post_lo", 32'h89ABCDEF, 4'hF, LE);
    check("post_empty_ovalid", 64'(ovalid_a), 64'd0);
    check("post_empty_iready", 64'(iready_a), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
